// File: rtl/lc3_pkg.sv
// Shared encodings for the sequential LC-3 ALU: operation selects, FSM states
// and the condition-code value held while the result register is zero.
package lc3_pkg;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_AND  = 3'b001;
    localparam logic [2:0] ALU_NOT  = 3'b010;
    localparam logic [2:0] ALU_PASS = 3'b011;
    localparam logic [2:0] ALU_MUL  = 3'b100;
    localparam logic [2:0] ALU_SHL  = 3'b101;
    localparam logic [2:0] ALU_SHR  = 3'b110;
    localparam logic [2:0] ALU_SRA  = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [2:0] NZP_Z = 3'b010;

endpackage

// File: rtl/lc3_alu_iter.sv
// Iterative datapath for shift-and-add multiply and one-bit-per-cycle shifts.
// res_step_o is the value after the step taken this cycle.
module lc3_alu_iter
    import lc3_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_i,
    input  logic               step_i,
    input  logic [2:0]         op_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic               zero_cnt_o,
    output logic [WIDTH-1:0]   res_step_o
);

    logic [2:0]         op_q;
    logic [WIDTH-1:0]   opa_q;
    logic [WIDTH-1:0]   opb_q;
    logic [WIDTH-1:0]   acc_q;
    logic [SHAMT_W-1:0] cnt_q;
    logic [WIDTH-1:0]   acc_d;
    logic [WIDTH-1:0]   sh_d;

    always_comb begin
        acc_d = opb_q[0] ? acc_q + opa_q : acc_q;
        case (op_q)
            ALU_SHL: sh_d = {opa_q[WIDTH-2:0], 1'b0};
            ALU_SHR: sh_d = {1'b0, opa_q[WIDTH-1:1]};
            ALU_SRA: sh_d = {opa_q[WIDTH-1], opa_q[WIDTH-1:1]};
            default: sh_d = opa_q;
        endcase
        res_step_o = (op_q == ALU_MUL) ? acc_d : sh_d;
        zero_cnt_o = (cnt_q == '0);
    end

    // Counter holds remaining steps minus one, so the final step and the
    // result write share one edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q  <= ALU_ADD;
            opa_q <= '0;
            opb_q <= '0;
            acc_q <= '0;
            cnt_q <= '0;
        end else if (load_i) begin
            op_q  <= op_i;
            opa_q <= a_i;
            opb_q <= b_i;
            acc_q <= '0;
            cnt_q <= (op_i == ALU_MUL) ? SHAMT_W'(WIDTH - 1)
                                       : b_i[SHAMT_W-1:0] - SHAMT_W'(1);
        end else if (step_i) begin
            if (op_q == ALU_MUL) begin
                acc_q <= acc_d;
                opa_q <= {opa_q[WIDTH-2:0], 1'b0};
                opb_q <= {1'b0, opb_q[WIDTH-1:1]};
            end else begin
                opa_q <= sh_d;
            end
            cnt_q <= cnt_q - SHAMT_W'(1);
        end
    end

endmodule

// File: rtl/lc3_alu_seq.sv
// Registered LC-3 ALU with start/busy/done handshake, NZP flags and a
// tri-state drive onto the shared main bus.
module lc3_alu_seq
    import lc3_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int IMM_WIDTH = 5,
    parameter int SHAMT_W   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [15:0]      ir,
    input  logic [WIDTH-1:0] sr1,
    input  logic [WIDTH-1:0] sr2,
    input  logic [2:0]       aluk,
    input  logic             start,
    input  logic             gate_alu,
    output logic             busy,
    output logic             done,
    output logic [2:0]       nzp,
    output logic [WIDTH-1:0] main_bus
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [2:0]       nzp_q;
    logic             upd;
    logic             load;
    logic             step;
    logic             zero_cnt;
    logic [WIDTH-1:0] res_step;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] quick;
    logic             unused_ir;

    function automatic logic [2:0] nzp_of(input logic [WIDTH-1:0] r);
        nzp_of = {r[WIDTH-1], r == '0, !r[WIDTH-1] && (r != '0)};
    endfunction

    assign unused_ir = ^ir[15:IMM_WIDTH+1];
    assign opb = ir[IMM_WIDTH] ? {{(WIDTH-IMM_WIDTH){ir[IMM_WIDTH-1]}}, ir[IMM_WIDTH-1:0]}
                               : sr2;

    // Shifts by zero complete like the single-cycle ops and return operand A.
    always_comb begin
        case (aluk)
            ALU_ADD: quick = sr1 + opb;
            ALU_AND: quick = sr1 & opb;
            ALU_NOT: quick = ~sr1;
            default: quick = sr1;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        upd      = 1'b0;
        load     = 1'b0;
        step     = 1'b0;
        case (state_q)
            ST_RUN: begin
                step = 1'b1;
                if (zero_cnt) begin
                    result_d = res_step;
                    upd      = 1'b1;
                    state_d  = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                if (start) begin
                    if (aluk == ALU_MUL || (aluk[2] && opb[SHAMT_W-1:0] != '0)) begin
                        load    = 1'b1;
                        state_d = ST_RUN;
                    end else begin
                        result_d = quick;
                        upd      = 1'b1;
                        state_d  = ST_DONE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            nzp_q    <= NZP_Z;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            if (upd) nzp_q <= nzp_of(result_d);
        end
    end

    lc3_alu_iter #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W)
    ) u_iter (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (load),
        .step_i     (step),
        .op_i       (aluk),
        .a_i        (sr1),
        .b_i        (opb),
        .zero_cnt_o (zero_cnt),
        .res_step_o (res_step)
    );

    assign busy     = (state_q == ST_RUN);
    assign done     = (state_q == ST_DONE);
    assign nzp      = nzp_q;
    assign main_bus = gate_alu ? result_q : {WIDTH{1'bz}};

endmodule

// File: tb/tb_lc3_alu_seq.sv
// Directed testbench for lc3_alu_seq at WIDTH=16 and WIDTH=8.
module tb_lc3_alu_seq;

    localparam logic [2:0] K_ADD = 3'b000, K_AND = 3'b001, K_PASS = 3'b011, K_MUL = 3'b100,
                           K_SHL = 3'b101, K_SHR = 3'b110, K_SRA = 3'b111;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] ir = '0, sr1 = '0, sr2 = '0;
    logic [2:0]  aluk = '0;
    logic        start = 1'b0, gate_alu = 1'b0;
    logic        busy, done;
    logic [2:0]  nzp;
    wire  [15:0] bus;

    logic [15:0] ir8 = '0;
    logic [7:0]  sr1_8 = '0, sr2_8 = '0;
    logic [2:0]  aluk8 = '0;
    logic        start8 = 1'b0, gate8 = 1'b0;
    logic        busy8, done8;
    logic [2:0]  nzp8;
    wire  [7:0]  bus8;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 16; g++) begin : g_pd
        pulldown (bus[g]);
    end

    lc3_alu_seq #(.WIDTH(16), .IMM_WIDTH(5), .SHAMT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .ir(ir), .sr1(sr1), .sr2(sr2), .aluk(aluk),
        .start(start), .gate_alu(gate_alu), .busy(busy), .done(done), .nzp(nzp),
        .main_bus(bus)
    );

    lc3_alu_seq #(.WIDTH(8), .IMM_WIDTH(5), .SHAMT_W(3)) dut8 (
        .clk(clk), .rst_n(rst_n), .ir(ir8), .sr1(sr1_8), .sr2(sr2_8), .aluk(aluk8),
        .start(start8), .gate_alu(gate8), .busy(busy8), .done(done8), .nzp(nzp8),
        .main_bus(bus8)
    );

    // Called at a falling edge; returns at the falling edge where done is seen.
    task automatic issue(input logic [2:0] k, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] i, input bit w8, output int lat, output int nbusy);
        if (w8) begin
            aluk8 = k; sr1_8 = a[7:0]; sr2_8 = b[7:0]; ir8 = i; start8 = 1'b1;
        end else begin
            aluk = k; sr1 = a; sr2 = b; ir = i; start = 1'b1;
        end
        @(negedge clk);
        start = 1'b0; start8 = 1'b0;
        lat = 1; nbusy = 0;
        while (!(w8 ? done8 : done) && lat < 100) begin
            if (w8 ? busy8 : busy) nbusy++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic read_bus(output logic [15:0] v);
        gate_alu = 1'b1;
        #1 v = bus;
        gate_alu = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        logic [15:0] v;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        n_checks++; if (nzp !== 3'b010) begin n_fail++; $display("FAIL reset_nzp: got %b expected 010", nzp); end
        read_bus(v);
        n_checks++; if (v !== 16'h0000) begin n_fail++; $display("FAIL reset_result: got %h expected 0000", v); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_add();
        int lat, nb;
        logic [15:0] v;
        issue(K_ADD, 16'h0005, 16'h0000, 16'h003D, 1'b0, lat, nb);
        n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL add_latency: got %0d expected 1", lat); end
        n_checks++; if (nzp !== 3'b001) begin n_fail++; $display("FAIL add_nzp: got %b expected 001", nzp); end
        read_bus(v);
        n_checks++; if (v !== 16'h0002) begin n_fail++; $display("FAIL add_bus: got %h expected 0002", v); end
        n_checks++; if (bus !== 16'h0000) begin n_fail++; $display("FAIL bus_released: got %h expected pulled 0000", bus); end
        @(negedge clk);
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL add_done_width: got %b expected 0", done); end
    endtask

    task automatic test_mul();
        int lat, nb;
        logic [15:0] v;
        issue(K_MUL, 16'h0007, 16'h0009, 16'h0000, 1'b0, lat, nb);
        n_checks++; if (lat !== 17) begin n_fail++; $display("FAIL mul_latency: got %0d expected 17", lat); end
        n_checks++; if (nb !== 16) begin n_fail++; $display("FAIL mul_busy_cycles: got %0d expected 16", nb); end
        read_bus(v);
        n_checks++; if (v !== 16'h003F) begin n_fail++; $display("FAIL mul_7x9: got %h expected 003f", v); end
        n_checks++; if (nzp !== 3'b001) begin n_fail++; $display("FAIL mul_7x9_nzp: got %b expected 001", nzp); end
        @(negedge clk);
        issue(K_MUL, 16'hFFFF, 16'h0002, 16'h0000, 1'b0, lat, nb);
        read_bus(v);
        n_checks++; if (v !== 16'hFFFE) begin n_fail++; $display("FAIL mul_ffff_x2: got %h expected fffe", v); end
        n_checks++; if (nzp !== 3'b100) begin n_fail++; $display("FAIL mul_ffff_x2_nzp: got %b expected 100", nzp); end
        @(negedge clk);
    endtask

    task automatic test_shifts();
        int lat, nb;
        logic [15:0] v;
        issue(K_SRA, 16'h8000, 16'h0000, 16'h0024, 1'b0, lat, nb);
        read_bus(v);
        n_checks++; if (v !== 16'hF800) begin n_fail++; $display("FAIL sra_8000_4: got %h expected f800", v); end
        n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL sra_latency: got %0d expected 5", lat); end
        n_checks++; if (nzp !== 3'b100) begin n_fail++; $display("FAIL sra_nzp: got %b expected 100", nzp); end
        @(negedge clk);
        issue(K_SHR, 16'h8000, 16'h0004, 16'h0000, 1'b0, lat, nb);
        read_bus(v);
        n_checks++; if (v !== 16'h0800) begin n_fail++; $display("FAIL shr_8000_4: got %h expected 0800", v); end
        @(negedge clk);
        issue(K_SHL, 16'h1234, 16'h0000, 16'h0020, 1'b0, lat, nb);
        read_bus(v);
        n_checks++; if (v !== 16'h1234) begin n_fail++; $display("FAIL shl_by0: got %h expected 1234", v); end
        n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL shl_by0_latency: got %0d expected 1", lat); end
        @(negedge clk);
        issue(K_SHL, 16'h0001, 16'h0000, 16'h002F, 1'b0, lat, nb);
        read_bus(v);
        n_checks++; if (v !== 16'h8000) begin n_fail++; $display("FAIL shl_1_by15: got %h expected 8000", v); end
        n_checks++; if (lat !== 16) begin n_fail++; $display("FAIL shl_by15_latency: got %0d expected 16", lat); end
        @(negedge clk);
    endtask

    task automatic test_ignore_start();
        int lat;
        logic [15:0] v;
        aluk = K_MUL; sr1 = 16'h0007; sr2 = 16'h0009; ir = 16'h0000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (!done && lat < 100) begin
            if (lat == 5) begin
                start = 1'b1; aluk = K_ADD; sr1 = 16'h0001; sr2 = 16'h0001;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        n_checks++; if (lat !== 17) begin n_fail++; $display("FAIL ignore_latency: got %0d expected 17", lat); end
        read_bus(v);
        n_checks++; if (v !== 16'h003F) begin n_fail++; $display("FAIL ignore_result: got %h expected 003f", v); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int lat, nb;
        logic [15:0] v;
        issue(K_PASS, 16'h1111, 16'h0000, 16'h0000, 1'b0, lat, nb);
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL b2b_first_done: got %b expected 1", done); end
        issue(K_AND, 16'h0F0F, 16'h00FF, 16'h0000, 1'b0, lat, nb);
        n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL b2b_latency: got %0d expected 1", lat); end
        read_bus(v);
        n_checks++; if (v !== 16'h000F) begin n_fail++; $display("FAIL b2b_and: got %h expected 000f", v); end
        @(negedge clk);
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL b2b_done_drop: got %b expected 0", done); end
    endtask

    task automatic test_reset_mid();
        int seen, lat, nb;
        logic [15:0] v;
        aluk = K_MUL; sr1 = 16'h0007; sr2 = 16'h0009; ir = 16'h0000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        gate_alu = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        n_checks++; if (nzp !== 3'b010) begin n_fail++; $display("FAIL midrst_nzp: got %b expected 010", nzp); end
        n_checks++; if (bus !== 16'h0000) begin n_fail++; $display("FAIL midrst_result: got %h expected 0000", bus); end
        gate_alu = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) seen++;
        end
        n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL midrst_no_done: got %0d pulses expected 0", seen); end
        issue(K_MUL, 16'h0003, 16'h0005, 16'h0000, 1'b0, lat, nb);
        read_bus(v);
        n_checks++; if (v !== 16'h000F) begin n_fail++; $display("FAIL midrst_next_op: got %h expected 000f", v); end
        @(negedge clk);
    endtask

    task automatic test_width8();
        int lat, nb;
        logic [7:0] v;
        issue(K_ADD, 16'h007F, 16'h0001, 16'h0000, 1'b1, lat, nb);
        gate8 = 1'b1;
        #1 v = bus8;
        gate8 = 1'b0;
        n_checks++; if (v !== 8'h80) begin n_fail++; $display("FAIL w8_add: got %h expected 80", v); end
        n_checks++; if (nzp8 !== 3'b100) begin n_fail++; $display("FAIL w8_add_nzp: got %b expected 100", nzp8); end
        @(negedge clk);
        issue(K_MUL, 16'h0003, 16'h0005, 16'h0000, 1'b1, lat, nb);
        n_checks++; if (lat !== 9) begin n_fail++; $display("FAIL w8_mul_latency: got %0d expected 9", lat); end
        gate8 = 1'b1;
        #1 v = bus8;
        gate8 = 1'b0;
        n_checks++; if (v !== 8'h0F) begin n_fail++; $display("FAIL w8_mul: got %h expected 0f", v); end
        n_checks++; if (busy8 !== 1'b0) begin n_fail++; $display("FAIL w8_busy_at_done: got %b expected 0", busy8); end
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_add();
        test_mul();
        test_shifts();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        test_width8();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lc3_alu_seq.md
Name: lc3_alu_seq

Overview:
Parametrised, registered successor of the LC-3 datapath ALU.
- Adds iterative multi-cycle operations: multiply, logical/arithmetic shifts.
- Adds a start/busy/done handshake with the control FSM.
- Adds a registered result and NZP condition-code outputs.
- Sits between the register file read ports and the shared main bus, which it drives through a tri-state gate.

Parameters:
WIDTH, 16, datapath and bus width in bits (>= 8).
IMM_WIDTH, 5, immediate field width in IR; ir[IMM_WIDTH] is the immediate-select bit.
SHAMT_W, 4, shift-amount bits taken from operand B; must equal clog2(WIDTH).

Ports:
clk  input  1  system clock, rising-edge.
rst_n  input  1  asynchronous active-low reset.
ir  input  16  instruction register; supplies the immediate-select bit and the immediate field.
sr1  input  WIDTH  operand A.
sr2  input  WIDTH  operand B when the immediate is not selected.
aluk  input  3  operation select: 000 ADD, 001 AND, 010 NOT, 011 PASSA, 100 MUL, 101 SHL, 110 SHR, 111 SRA.
start  input  1  one-cycle request; samples operands and aluk.
gate_alu  input  1  drive main_bus with result register.
busy  output  1  operation in progress.
done  output  1  one-cycle pulse when the result register updates.
nzp  output  3  condition codes of the result register {N,Z,P}.
main_bus  output  WIDTH  result when gate_alu=1, else high-Z.

Behaviour:
Clock and reset:
- One clock, clk; reset is asynchronous and active-low, rst_n.
- On reset: state=IDLE, result_q=0, busy=0, done=0, nzp=3'b010, all iteration registers 0.

Operand B:
- b = ir[IMM_WIDTH] ? sign-extended ir[IMM_WIDTH-1:0] : sr2.
- b is sampled at start; later operand changes do not affect an operation in flight.

State machine (IDLE, RUN, DONE):
- IDLE, start=1, aluk in {000..011}: go to DONE; result_q is written at that same edge (latency 1 cycle).
- IDLE, start=1, aluk=MUL: latch A and B, clear accumulator, count=WIDTH, go to RUN.
- IDLE, start=1, shift op: latch A, count = b[SHAMT_W-1:0], go to RUN.
- RUN, MUL: each cycle, if B[0] then acc += A; A <<= 1; B >>= 1; count--.
- RUN, shifts: each cycle shift the operand by one bit; count--.
  - SHL fills 0.
  - SHR fills 0.
  - SRA replicates the MSB.
- RUN, count==0 at the start of a cycle: write result_q and go to DONE.
  - MUL latency = WIDTH+1 cycles.
  - Shift latency = shamt+1 cycles; shamt=0 gives 1 cycle.
- DONE: done=1 for exactly one cycle, then go to IDLE.
  - start asserted in DONE is accepted as a new IDLE start in the same cycle (back-to-back ops allowed).
- busy=1 in RUN only.

Start rules:
- start in RUN is ignored; no queueing.
- start with gate_alu=1 is legal.

Arithmetic:
- ADD and MUL are modulo 2^WIDTH; only the low WIDTH bits of the product are kept.
- No carry or overflow flags.

Result and flags:
- nzp updates only when result_q updates:
  - N = result MSB;
  - Z = result==0;
  - P = !N & !Z.
- main_bus is purely combinational from gate_alu and result_q, which holds the last completed result.
- gate_alu during RUN drives the previous result.

Reset mid-operation:
- Aborts the operation immediately; no done pulse; result_q returns to 0.

Decomposition:
Shared package lc3_pkg:
- aluk localparams: ALU_ADD, ALU_AND, ALU_NOT, ALU_PASS, ALU_MUL, ALU_SHL, ALU_SHR, ALU_SRA.
- State encoding: ST_IDLE, ST_RUN, ST_DONE.
- NZP reset constant NZP_Z=3'b010.

One natural sub-module: lc3_alu_iter.
- Holds the shift/multiply datapath: operand, accumulator and counter registers.
- Exposes load, step and zero-count.
- Keeps the FSM and bus gating in the top.

Test Plan:
- Reset, then ADD: sr1=16'h0005, ir[5]=1, ir[4:0]=5'b11101 (-3), start -> done after 1 cycle, result 16'h0002, nzp=001; gate_alu=1 drives 16'h0002, gate_alu=0 gives main_bus high-Z.
- MUL: sr1=16'h0007, sr2=16'h0009, ir[5]=0 -> busy for 16 cycles, done at cycle 17, result 16'h003F. Also 16'hFFFF*16'h0002 -> 16'hFFFE, nzp=100.
- Shifts:
  - SRA of 16'h8000 by 4 -> 16'hF800;
  - SHR of 16'h8000 by 4 -> 16'h0800;
  - SHL by 0 -> done after 1 cycle, result unchanged;
  - SHL of 16'h0001 by 15 -> 16'h8000 after 16 cycles.
- Protocol:
  - start pulsed during MUL RUN is ignored, with no change in done timing.
  - start asserted in the DONE cycle launches a new AND op: 16'h0F0F & 16'h00FF -> 16'h000F.
- Reset mid-MUL at cycle 5: busy=0, result_q=0, nzp=010 asynchronously, no done pulse; the next op completes normally.
- Parameter sweep with WIDTH=8, SHAMT_W=3:
  - ADD 8'h7F+8'h01 -> 8'h80, nzp=100;
  - MUL latency 9 cycles.
